// File: rtl/conf_editor.sv
//------------------------------------------------------------------------------
// Module   : conf_editor
// Purpose  : Front-panel editor for the Morse configuration bank; browses
//            fields, edits BCD digits and writes the result back.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module conf_editor #(
    parameter int DIGITS = 6,
    parameter int FIELDS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  btn_field,
    input  logic                  btn_digit,
    input  logic                  btn_inc,
    input  logic                  btn_dec,
    input  logic                  btn_enter,
    input  logic                  btn_cancel,
    output logic [2:0]            selected_index,
    input  logic [DIGITS*4-1:0]   selected_value,
    output logic [DIGITS*4-1:0]   selected_new_value,
    output logic                  selected_set,
    output logic [DIGITS*4-1:0]   display_value,
    output logic [2:0]            cursor,
    output logic                  editing,
    output logic                  reject
);

    // Pulses-per-unit must never be committed as zero.
    localparam logic [2:0] c_PPU_INDEX  = 3'd4;
    localparam logic [2:0] c_LAST_FIELD = 3'(FIELDS - 1);
    localparam logic [2:0] c_LAST_DIGIT = 3'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_BROWSE = 2'd0,
        ST_LOAD   = 2'd1,
        ST_EDIT   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t                r_state;
    logic [2:0]            r_index;
    logic [DIGITS*4-1:0]   r_buf;
    logic [2:0]            r_cursor;
    logic                  r_set;
    logic                  r_editing;
    logic                  r_reject;

    logic                  w_act_cancel;
    logic                  w_act_enter;
    logic                  w_act_digit;
    logic                  w_act_inc;
    logic                  w_act_dec;
    logic                  w_act_field;
    logic [4:0]            w_digit_lsb;
    logic [3:0]            w_digit;
    logic [3:0]            w_digit_inc;
    logic [3:0]            w_digit_dec;
    logic                  w_guard;

    // Strict priority: only the highest-priority pressed button acts.
    assign w_act_cancel = btn_cancel;
    assign w_act_enter  = btn_enter & ~btn_cancel;
    assign w_act_digit  = btn_digit & ~btn_cancel & ~btn_enter;
    assign w_act_inc    = btn_inc   & ~btn_cancel & ~btn_enter & ~btn_digit;
    assign w_act_dec    = btn_dec   & ~btn_cancel & ~btn_enter & ~btn_digit & ~btn_inc;
    assign w_act_field  = btn_field & ~btn_cancel & ~btn_enter & ~btn_digit & ~btn_inc
                                    & ~btn_dec;

    assign w_digit_lsb = {r_cursor, 2'b00};
    assign w_digit     = r_buf[w_digit_lsb +: 4];

    // Non-BCD codes (A-F) snap to 0 on increment and 9 on decrement.
    assign w_digit_inc = (w_digit >= 4'd9) ? 4'd0 : w_digit + 4'd1;
    assign w_digit_dec = ((w_digit == 4'd0) || (w_digit > 4'd9)) ? 4'd9 : w_digit - 4'd1;

    assign w_guard = (r_index == c_PPU_INDEX) && (r_buf == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_BROWSE;
            r_index   <= 3'd0;
            r_buf     <= '0;
            r_cursor  <= 3'd0;
            r_set     <= 1'b0;
            r_editing <= 1'b0;
            r_reject  <= 1'b0;
        end else if (ce) begin
            r_reject <= 1'b0;
            case (r_state)
                ST_BROWSE: begin
                    if (w_act_enter) begin
                        r_state   <= ST_LOAD;
                        r_editing <= 1'b1;
                    end else if (w_act_field) begin
                        r_index <= (r_index == c_LAST_FIELD) ? 3'd0 : r_index + 3'd1;
                    end
                end
                ST_LOAD: begin
                    r_buf    <= selected_value;
                    r_cursor <= 3'd0;
                    r_state  <= ST_EDIT;
                end
                ST_EDIT: begin
                    if (w_act_cancel) begin
                        r_state   <= ST_BROWSE;
                        r_editing <= 1'b0;
                    end else if (w_act_enter) begin
                        if (w_guard) begin
                            r_reject <= 1'b1;
                        end else begin
                            r_state <= ST_COMMIT;
                            r_set   <= 1'b1;
                        end
                    end else if (w_act_digit) begin
                        r_cursor <= (r_cursor == c_LAST_DIGIT) ? 3'd0 : r_cursor + 3'd1;
                    end else if (w_act_inc) begin
                        r_buf[w_digit_lsb +: 4] <= w_digit_inc;
                    end else if (w_act_dec) begin
                        r_buf[w_digit_lsb +: 4] <= w_digit_dec;
                    end
                end
                ST_COMMIT: begin
                    r_state   <= ST_BROWSE;
                    r_set     <= 1'b0;
                    r_editing <= 1'b0;
                end
                default: begin
                    r_state   <= ST_BROWSE;
                    r_set     <= 1'b0;
                    r_editing <= 1'b0;
                end
            endcase
        end
    end

    assign selected_index     = r_index;
    assign selected_new_value = r_buf;
    assign selected_set       = r_set;
    assign cursor             = r_cursor;
    assign editing            = r_editing;
    assign reject             = r_reject;
    assign display_value      = ((r_state == ST_EDIT) || (r_state == ST_COMMIT)) ? r_buf
                                                                                 : selected_value;

endmodule

`default_nettype wire
